final_stage: RTL and testbench
==============================

Name: final_stage

Overview:
- Output-arbitration and end-of-run stage for the monopix2 chip model's four LVDS outputs.
- Registers two independent update sources:
  - combinational-path samples;
  - sequential (clock-edge) samples.
- Tags every accepted update with a monotonically increasing sequence number and drives the outputs from whichever source was updated most recently.
- A finalize request freezes the block and reports completion.

Parameters:
- NOUT, 4, number of output bits per source (CHSYNC_CLK, DATA, HITOR, CHSYNC_LOCKED).
- SEQ_W, 16, width of the sequence counter and the stored sequence numbers.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- COMBO_VALID  input  1  combinational-source update strobe.
- COMBO_DATA  input  NOUT  combinational-source sample.
- SEQ_VALID  input  1  sequential-source update strobe.
- SEQ_DATA  input  NOUT  sequential-source sample.
- FINAL_REQ  input  1  finalize request (level; sampled each cycle).
- DATA_OUT  output  NOUT  selected output sample.
- SRC_SEQ  output  1  1 = DATA_OUT comes from the sequential register.
- LAST_COMBO_SEQNUM  output  SEQ_W  tag of the last accepted combinational update.
- LAST_SEQ_SEQNUM  output  SEQ_W  tag of the last accepted sequential update.
- OVERFLOW  output  1  sticky; the sequence counter has saturated.
- FINAL_DONE  output  1  high while in DONE state.

Behaviour:
- Reset (async, RST=1) clears:
  - counter, both data registers and both seqnum registers;
  - OVERFLOW and FINAL_DONE;
  - state goes to RUN; DATA_OUT=0, SRC_SEQ=0.
- States:
  - RUN -> DONE when FINAL_REQ=1 at a rising edge.
  - DONE is terminal; only RST exits it.
- Updates are accepted in RUN only, with OVERFLOW=0:
  - COMBO_VALID alone: combo_reg<=COMBO_DATA; LAST_COMBO_SEQNUM<=cnt+1; cnt<=cnt+1.
  - SEQ_VALID alone: seq_reg<=SEQ_DATA; LAST_SEQ_SEQNUM<=cnt+1; cnt<=cnt+1.
  - Both in the same cycle: combo tag is cnt+1, seq tag is cnt+2, cnt<=cnt+2. The sequential source wins.
- Selection is combinational from the registers, so an input update appears on DATA_OUT one cycle after its strobe:
  - SRC_SEQ = (LAST_SEQ_SEQNUM > LAST_COMBO_SEQNUM);
  - DATA_OUT = SRC_SEQ ? seq_reg : combo_reg;
  - a tie (including after reset) selects combo.
- Saturation:
  - If an accepted update would take cnt beyond 2^SEQ_W-1, that update and all later ones are dropped entirely: no register, tag or counter change.
  - OVERFLOW is set the same cycle and stays set until reset.
  - A dual update with only one tag left is treated the same way: both are dropped.
- FINAL_REQ together with a valid strobe in the same cycle: the update is accepted, then the state enters DONE.
- In DONE:
  - all strobes are ignored and DATA_OUT and SRC_SEQ are frozen;
  - FINAL_DONE=1 from the cycle after the request.
- FINAL_REQ held or repeated while in DONE has no effect.

Optional Feature:
- Macro: FINAL_STAGE_HASH_CHECK_EN.
- When defined:
  - adds parameter HASH (32 bits, default 32'd2954403249), input HASH_IN[31:0] and output HASH_ERR.
  - HASH_IN is sampled on the first rising edge after reset deasserts.
  - On mismatch, HASH_ERR is set sticky, DATA_OUT is forced to 0, and updates are ignored until reset.
  - On a match, behaviour is identical to the base block.
- When undefined: none of these ports exist and no check is performed.

Decomposition:
- Package final_stage_pkg:
  - state enum {RUN, DONE};
  - default NOUT/SEQ_W constants;
  - default HASH constant.
- Sub-module final_stage_seqcnt:
  - saturating counter;
  - computes the two tags and the overflow condition from the strobe pair;
  - produces the accept signal.
- Selection mux, data registers and the state machine live in the top module.

Test Plan:
- Reset then idle: DATA_OUT=0, SRC_SEQ=0, both seqnums 0, FINAL_DONE=0.
- Combo update 4'b1010: next cycle DATA_OUT=1010, LAST_COMBO_SEQNUM=1, SRC_SEQ=0. Then seq update 4'b0101: DATA_OUT=0101, LAST_SEQ_SEQNUM=2, SRC_SEQ=1.
- Simultaneous COMBO 4'b0011 / SEQ 4'b1100 from cnt=2: tags 3/4, DATA_OUT=1100, SRC_SEQ=1.
- SEQ_W=3, eight single updates:
  - the 7th is accepted (tag 7);
  - the 8th is dropped and OVERFLOW=1;
  - DATA_OUT keeps the 7th value.
- FINAL_REQ with COMBO_VALID 4'b1111:
  - update applied, FINAL_DONE=1 next cycle;
  - later strobes do not change DATA_OUT;
  - RST asserted mid-DONE clears everything asynchronously.
- With FINAL_STAGE_HASH_CHECK_EN: HASH_IN=0 after reset gives HASH_ERR=1, DATA_OUT=0 despite updates; HASH_IN=HASH gives normal operation.

Source files
------------

// File: rtl/final_stage_pkg.sv
// Shared types and default constants for the final_stage output-arbitration block.
package final_stage_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int          NOUT_DEF  = 4;
    localparam int          SEQ_W_DEF = 16;
    localparam logic [31:0] HASH_DEF  = 32'd2954403249;

endpackage

// File: rtl/final_stage_seqcnt.sv
// Saturating sequence counter: hands out tags for the combo/seq strobe pair and
// raises a sticky overflow once a request no longer fits in the counter range.
module final_stage_seqcnt #(
    parameter int SEQ_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             combo_valid,
    input  logic             seq_valid,
    output logic [SEQ_W-1:0] combo_tag,
    output logic [SEQ_W-1:0] seq_tag,
    output logic             accept,
    output logic             overflow
);

    logic [SEQ_W-1:0] cnt;
    logic [SEQ_W:0]   need;
    logic [SEQ_W:0]   room;
    logic             request;

    // NOTE: every signal written here gets a value on all paths, so no latch is inferred.
    always_comb begin
        need      = (SEQ_W+1)'(combo_valid) + (SEQ_W+1)'(seq_valid);
        room      = (SEQ_W+1)'({SEQ_W{1'b1}}) - (SEQ_W+1)'(cnt);
        request   = enable && !overflow && (combo_valid || seq_valid);
        // A dual request with a single tag left does not fit and is dropped whole.
        accept    = request && (need <= room);
        combo_tag = cnt + SEQ_W'(1);
        seq_tag   = combo_valid ? cnt + SEQ_W'(2) : cnt + SEQ_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + need[SEQ_W-1:0];
        end else if (request) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/final_stage.sv
// Output-arbitration / end-of-run stage: the most recently tagged source drives DATA_OUT.
// Optional power-on hash check enabled by defining FINAL_STAGE_HASH_CHECK_EN.
module final_stage
    import final_stage_pkg::*;
#(
    parameter int NOUT  = NOUT_DEF,
    parameter int SEQ_W = SEQ_W_DEF
`ifdef FINAL_STAGE_HASH_CHECK_EN
    ,
    parameter logic [31:0] HASH = HASH_DEF
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             COMBO_VALID,
    input  logic [NOUT-1:0]  COMBO_DATA,
    input  logic             SEQ_VALID,
    input  logic [NOUT-1:0]  SEQ_DATA,
    input  logic             FINAL_REQ,
`ifdef FINAL_STAGE_HASH_CHECK_EN
    input  logic [31:0]      HASH_IN,
    output logic             HASH_ERR,
`endif
    output logic [NOUT-1:0]  DATA_OUT,
    output logic             SRC_SEQ,
    output logic [SEQ_W-1:0] LAST_COMBO_SEQNUM,
    output logic [SEQ_W-1:0] LAST_SEQ_SEQNUM,
    output logic             OVERFLOW,
    output logic             FINAL_DONE
);

    state_t           state;
    state_t           state_next;
    logic [NOUT-1:0]  combo_reg;
    logic [NOUT-1:0]  seq_reg;
    logic [SEQ_W-1:0] combo_tag;
    logic [SEQ_W-1:0] seq_tag;
    logic             accept;
    logic             hash_ok;
    logic             update_en;

`ifdef FINAL_STAGE_HASH_CHECK_EN
    logic hash_checked;
    logic hash_err;

    // The first edge after reset both latches the verdict and gates that edge's updates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hash_checked <= 1'b0;
            hash_err     <= 1'b0;
        end else if (!hash_checked) begin
            hash_checked <= 1'b1;
            hash_err     <= (HASH_IN != HASH);
        end
    end

    assign hash_ok  = hash_checked ? !hash_err : (HASH_IN == HASH);
    assign HASH_ERR = hash_err;
`else
    assign hash_ok = 1'b1;
`endif

    assign update_en = (state == RUN) && hash_ok;

    final_stage_seqcnt #(
        .SEQ_W(SEQ_W)
    ) u_seqcnt (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (update_en),
        .combo_valid(COMBO_VALID),
        .seq_valid  (SEQ_VALID),
        .combo_tag  (combo_tag),
        .seq_tag    (seq_tag),
        .accept     (accept),
        .overflow   (OVERFLOW)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            combo_reg         <= '0;
            seq_reg           <= '0;
            LAST_COMBO_SEQNUM <= '0;
            LAST_SEQ_SEQNUM   <= '0;
        end else if (accept) begin
            if (COMBO_VALID) begin
                combo_reg         <= COMBO_DATA;
                LAST_COMBO_SEQNUM <= combo_tag;
            end
            if (SEQ_VALID) begin
                seq_reg         <= SEQ_DATA;
                LAST_SEQ_SEQNUM <= seq_tag;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (FINAL_REQ) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    // Equal tags (including the all-zero reset state) resolve to the combo source.
    assign SRC_SEQ    = (LAST_SEQ_SEQNUM > LAST_COMBO_SEQNUM);
    assign FINAL_DONE = (state == DONE);

`ifdef FINAL_STAGE_HASH_CHECK_EN
    assign DATA_OUT = hash_err ? '0 : (SRC_SEQ ? seq_reg : combo_reg);
`else
    assign DATA_OUT = SRC_SEQ ? seq_reg : combo_reg;
`endif

endmodule

// File: tb/tb_final_stage.sv
// Scoreboard bench for final_stage: a 16-bit and a 3-bit instance share stimulus.
module tb_final_stage;
    import final_stage_pkg::*;

    localparam int NOUT    = 4;
    localparam int SEQ_W   = 16;
    localparam int SMALL_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            combo_valid = 1'b0;
    logic [NOUT-1:0] combo_data  = '0;
    logic            seq_valid   = 1'b0;
    logic [NOUT-1:0] seq_data    = '0;
    logic            final_req   = 1'b0;

    logic [NOUT-1:0]    data_out, s_data_out;
    logic               src_seq, s_src_seq;
    logic [SEQ_W-1:0]   last_combo, last_seq;
    logic [SMALL_W-1:0] s_last_combo, s_last_seq;
    logic               overflow, s_overflow;
    logic               final_done, s_final_done;

`ifdef FINAL_STAGE_HASH_CHECK_EN
    logic [31:0] hash_in = HASH_DEF;
    logic        hash_err, s_hash_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    final_stage #(.NOUT(NOUT), .SEQ_W(SEQ_W)) dut (
        .CLK(clk), .RST(rst),
        .COMBO_VALID(combo_valid), .COMBO_DATA(combo_data),
        .SEQ_VALID(seq_valid), .SEQ_DATA(seq_data),
        .FINAL_REQ(final_req),
`ifdef FINAL_STAGE_HASH_CHECK_EN
        .HASH_IN(hash_in), .HASH_ERR(hash_err),
`endif
        .DATA_OUT(data_out), .SRC_SEQ(src_seq),
        .LAST_COMBO_SEQNUM(last_combo), .LAST_SEQ_SEQNUM(last_seq),
        .OVERFLOW(overflow), .FINAL_DONE(final_done)
    );

    final_stage #(.NOUT(NOUT), .SEQ_W(SMALL_W)) dut_small (
        .CLK(clk), .RST(rst),
        .COMBO_VALID(combo_valid), .COMBO_DATA(combo_data),
        .SEQ_VALID(seq_valid), .SEQ_DATA(seq_data),
        .FINAL_REQ(final_req),
`ifdef FINAL_STAGE_HASH_CHECK_EN
        .HASH_IN(hash_in), .HASH_ERR(s_hash_err),
`endif
        .DATA_OUT(s_data_out), .SRC_SEQ(s_src_seq),
        .LAST_COMBO_SEQNUM(s_last_combo), .LAST_SEQ_SEQNUM(s_last_seq),
        .OVERFLOW(s_overflow), .FINAL_DONE(s_final_done)
    );

    typedef struct {
        logic [3:0] data;
        logic       src;
        int         ctag;
        int         stag;
        logic       ovf;
        logic       done;
    } exp_t;

    exp_t q_big[$];
    exp_t q_small[$];

    int         m_cnt[2];
    int         m_ctag[2];
    int         m_stag[2];
    logic [3:0] m_combo[2];
    logic [3:0] m_seq[2];
    logic       m_ovf[2];
    logic       m_done[2];
    int         m_max[2] = '{65535, 7};

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_ctag[d] = 0; m_stag[d] = 0;
            m_combo[d] = '0; m_seq[d] = '0; m_ovf[d] = 1'b0; m_done[d] = 1'b0;
        end
    endfunction

    function automatic exp_t model_step(input int d, input logic cv, input logic [3:0] cd,
                                        input logic sv, input logic [3:0] sd, input logic fr);
        exp_t e;
        int   need;
        need = int'(cv) + int'(sv);
        if (!m_done[d] && !m_ovf[d] && need > 0) begin
            if (m_cnt[d] + need > m_max[d]) begin
                m_ovf[d] = 1'b1;
            end else begin
                if (cv) begin m_combo[d] = cd; m_ctag[d] = m_cnt[d] + 1; end
                if (sv) begin m_seq[d] = sd; m_stag[d] = m_cnt[d] + need; end
                m_cnt[d] = m_cnt[d] + need;
            end
        end
        if (fr) m_done[d] = 1'b1;
        e.src  = (m_stag[d] > m_ctag[d]);
        e.data = e.src ? m_seq[d] : m_combo[d];
        e.ctag = m_ctag[d];
        e.stag = m_stag[d];
        e.ovf  = m_ovf[d];
        e.done = m_done[d];
        return e;
    endfunction

    // Drive one cycle of stimulus, push expectations, then compare both instances.
    task automatic cycle(input logic cv, input logic [3:0] cd, input logic sv,
                         input logic [3:0] sd, input logic fr);
        exp_t e;
        logic [37:0] got_b, exp_b;
        logic [13:0] got_s, exp_s;
        combo_valid = cv; combo_data = cd; seq_valid = sv; seq_data = sd; final_req = fr;
        q_big.push_back(model_step(0, cv, cd, sv, sd, fr));
        q_small.push_back(model_step(1, cv, cd, sv, sd, fr));
        @(posedge clk);
        #1;
        e = q_big.pop_front();
        exp_b = {e.data, e.src, e.ctag[15:0], e.stag[15:0], e.ovf, e.done};
        got_b = {data_out, src_seq, last_combo, last_seq, overflow, final_done};
        checks++;
        if (got_b !== exp_b) begin
            errors++;
            $display("FAIL sb_big t=%0t: got %h expected %h", $time, got_b, exp_b);
        end
        e = q_small.pop_front();
        exp_s = {e.data, e.src, e.ctag[2:0], e.stag[2:0], e.ovf, e.done};
        got_s = {s_data_out, s_src_seq, s_last_combo, s_last_seq, s_overflow, s_final_done};
        checks++;
        if (got_s !== exp_s) begin
            errors++;
            $display("FAIL sb_small t=%0t: got %h expected %h", $time, got_s, exp_s);
        end
        combo_valid = 1'b0; seq_valid = 1'b0; final_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({data_out, src_seq, last_combo, last_seq, overflow, final_done} !== '0) begin
            errors++;
            $display("FAIL reset_big: got %h expected 0",
                     {data_out, src_seq, last_combo, last_seq, overflow, final_done});
        end
        checks++;
        if ({s_data_out, s_src_seq, s_last_combo, s_last_seq, s_overflow, s_final_done} !== '0) begin
            errors++;
            $display("FAIL reset_small: got %h expected 0",
                     {s_data_out, s_src_seq, s_last_combo, s_last_seq, s_overflow, s_final_done});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        checks++;
        if (final_done !== 1'b0 || src_seq !== 1'b0 || data_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle: got done=%b src=%b data=%h expected 0/0/0",
                     final_done, src_seq, data_out);
        end
    endtask

    task automatic test_combo_then_seq();
        cycle(1'b1, 4'b1010, 1'b0, 4'h0, 1'b0);
        checks++;
        if (data_out !== 4'b1010 || last_combo !== 16'd1 || src_seq !== 1'b0) begin
            errors++;
            $display("FAIL combo_update: got data=%b tag=%0d src=%b expected 1010/1/0",
                     data_out, last_combo, src_seq);
        end
        cycle(1'b0, 4'h0, 1'b1, 4'b0101, 1'b0);
        checks++;
        if (data_out !== 4'b0101 || last_seq !== 16'd2 || src_seq !== 1'b1) begin
            errors++;
            $display("FAIL seq_update: got data=%b tag=%0d src=%b expected 0101/2/1",
                     data_out, last_seq, src_seq);
        end
    endtask

    task automatic test_dual();
        cycle(1'b1, 4'b0011, 1'b1, 4'b1100, 1'b0);
        checks++;
        if (last_combo !== 16'd3 || last_seq !== 16'd4 || data_out !== 4'b1100 || src_seq !== 1'b1) begin
            errors++;
            $display("FAIL dual_update: got ctag=%0d stag=%0d data=%b src=%b expected 3/4/1100/1",
                     last_combo, last_seq, data_out, src_seq);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            v = 4'(i);
            cycle(1'b1, v, 1'b0, 4'h0, 1'b0);
            if (i == 7) begin
                checks++;
                if (s_overflow !== 1'b0 || s_last_combo !== 3'd7 || s_data_out !== 4'd7) begin
                    errors++;
                    $display("FAIL sat_seventh: got ovf=%b tag=%0d data=%0d expected 0/7/7",
                             s_overflow, s_last_combo, s_data_out);
                end
            end
        end
        checks++;
        if (s_overflow !== 1'b1 || s_last_combo !== 3'd7 || s_data_out !== 4'd7 || data_out !== 4'd8) begin
            errors++;
            $display("FAIL sat_eighth: got ovf=%b tag=%0d data=%0d big=%0d expected 1/7/7/8",
                     s_overflow, s_last_combo, s_data_out, data_out);
        end
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            v = 4'(i);
            cycle(1'b1, v, 1'b0, 4'h0, 1'b0);
        end
        cycle(1'b1, 4'hA, 1'b1, 4'hB, 1'b0);
        checks++;
        if (s_overflow !== 1'b1 || s_data_out !== 4'd6 || s_last_seq !== 3'd0 || s_last_combo !== 3'd6) begin
            errors++;
            $display("FAIL sat_dual: got ovf=%b data=%0d stag=%0d ctag=%0d expected 1/6/0/6",
                     s_overflow, s_data_out, s_last_seq, s_last_combo);
        end
        cycle(1'b0, 4'h0, 1'b1, 4'hC, 1'b0);
        checks++;
        if (s_last_seq !== 3'd0 || s_data_out !== 4'd6) begin
            errors++;
            $display("FAIL sat_sticky: got stag=%0d data=%0d expected 0/6", s_last_seq, s_data_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 150; i++) begin
            cycle(1'($urandom_range(1)), 4'($urandom), 1'($urandom_range(1)), 4'($urandom), 1'b0);
        end
    endtask

    task automatic test_final();
        do_reset();
        cycle(1'b1, 4'b0110, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0, 4'h0, 1'b1);
        checks++;
        if (final_done !== 1'b1 || data_out !== 4'b1111 || last_combo !== 16'd2) begin
            errors++;
            $display("FAIL final_enter: got done=%b data=%b tag=%0d expected 1/1111/2",
                     final_done, data_out, last_combo);
        end
        cycle(1'b0, 4'h0, 1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 4'b0010, 1'b1);
        checks++;
        if (final_done !== 1'b1 || data_out !== 4'b1111 || src_seq !== 1'b0 || last_seq !== 16'd0) begin
            errors++;
            $display("FAIL final_frozen: got done=%b data=%b src=%b stag=%0d expected 1/1111/0/0",
                     final_done, data_out, src_seq, last_seq);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (final_done !== 1'b0 || data_out !== 4'h0 || last_combo !== 16'd0) begin
            errors++;
            $display("FAIL final_async_reset: got done=%b data=%b tag=%0d expected 0/0000/0",
                     final_done, data_out, last_combo);
        end
        do_reset();
        cycle(1'b0, 4'h0, 1'b1, 4'b1001, 1'b0);
    endtask

`ifdef FINAL_STAGE_HASH_CHECK_EN
    task automatic test_hash();
        hash_in = 32'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            combo_valid = 1'b1; combo_data = 4'hF;
            @(posedge clk);
            #1;
        end
        combo_valid = 1'b0;
        checks++;
        if (hash_err !== 1'b1 || data_out !== 4'h0 || last_combo !== 16'd0) begin
            errors++;
            $display("FAIL hash_bad: got err=%b data=%h tag=%0d expected 1/0/0",
                     hash_err, data_out, last_combo);
        end
        hash_in = HASH_DEF;
        do_reset();
        cycle(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
        checks++;
        if (hash_err !== 1'b0 || data_out !== 4'h5) begin
            errors++;
            $display("FAIL hash_good: got err=%b data=%h expected 0/5", hash_err, data_out);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_combo_then_seq();
        test_dual();
        test_saturation();
        test_back_to_back();
        test_final();
`ifdef FINAL_STAGE_HASH_CHECK_EN
        test_hash();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
